regfile_dump: RTL and testbench

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_dump.sv | 109 ++++++++++
 tb/tb_regfile_dump.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file dump engine.
// The optional macro REGDUMP_SKIP_XZR_EN (used in regfile_dump.sv) drops the
// zero register from the dump.
package regfile_pkg;

    localparam int DATA_W  = 64;  // architectural register width
    localparam int REG_AW  = 5;   // register address width
    localparam int XZR_IDX = 31;  // index of the hard-wired zero register

    // Dump sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        VALID = 2'd2,
        DONE  = 2'd3
    } dump_state_t;

endpackage : regfile_pkg

// File: rtl/regfile_dump.sv
// regfile_dump: walks the register file through its combinational read port
// and streams every register out as a valid/ready beat tagged with its index.
// Build option: define REGDUMP_SKIP_XZR_EN to stop before the zero register.
module regfile_dump
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int N_REGS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [REG_AW-1:0] ra,
    input  logic [DATA_W-1:0] rd,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_AW-1:0] out_idx,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

`ifdef REGDUMP_SKIP_XZR_EN
    // The zero register always reads 0, so it is left out of the stream.
    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(N_REGS - 2);
`else
    localparam logic [REG_AW-1:0] LAST_IDX = REG_AW'(N_REGS - 1);
`endif

    dump_state_t       r_state;
    dump_state_t       w_state_next;
    logic [REG_AW-1:0] r_index;
    logic [REG_AW-1:0] w_index_next;
    logic              w_capture;
    logic [DATA_W-1:0] r_out_data;
    logic [REG_AW-1:0] r_out_idx;
    logic              r_done;

    // Next-state, index update and status decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_next = r_state;
        w_index_next = r_index;
        w_capture    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = READ;
                    w_index_next = '0;
                end
            end
            READ: begin
                w_capture    = 1'b1;
                w_state_next = VALID;
            end
            VALID: begin
                if (out_ready) begin
                    if (r_index == LAST_IDX) begin
                        w_state_next = DONE;
                    end else begin
                        w_index_next = r_index + 1'b1;
                        w_state_next = READ;
                    end
                end
            end
            DONE: begin
                // Park the index at 0 so the read address is 0 in IDLE.
                w_index_next = '0;
                w_state_next = IDLE;
            end
            default: begin
                w_index_next = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    // State, index, captured beat and done pulse; reset wins over everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state    <= IDLE;
            r_index    <= '0;
            r_out_data <= '0;
            r_out_idx  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
            if (w_capture) begin
                r_out_data <= rd;
                r_out_idx  <= r_index;
            end
            // Registered so the pulse follows the DONE state by one cycle
            // and is killed by a reset landing in DONE.
            r_done <= (r_state == DONE);
        end
    end

    assign ra        = r_index;
    assign out_data  = r_out_data;
    assign out_idx   = r_out_idx;
    assign out_valid = (r_state == VALID);
    assign busy      = (r_state == READ) || (r_state == VALID);
    assign done      = r_done;

endmodule : regfile_dump

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a behavioural register file as the
// read-port partner (synchronous write port, combinational read, XZR reads 0).
module tb_regfile_dump;
    import regfile_pkg::*;

`ifdef REGDUMP_SKIP_XZR_EN
    localparam int LAST = 30;
`else
    localparam int LAST = 31;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic [REG_AW-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] out_data;
    logic [REG_AW-1:0] out_idx;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
    logic              done;

    // Register-file model
    logic              we;
    logic [REG_AW-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] mem [0:31];

    int n_tests = 0;
    int n_fail  = 0;
    int x5_val  = 5;

    regfile_dump #(.DATA_W(DATA_W), .N_REGS(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ra        (ra),
        .rd        (rd),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write port of the model; memory contents are only ever set by writes.
    always @(posedge clk) begin
        if (we && (wa != REG_AW'(XZR_IDX))) mem[wa] <= wd;
    end

    assign rd = (ra == REG_AW'(XZR_IDX)) ? '0 : mem[ra];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_data(input int i);
        if (i == 31) return 64'd0;
        if (i == 5)  return 64'(x5_val);
        return 64'(i);
    endfunction

    task automatic write_reg(input int idx, input int val);
        we = 1'b1;
        wa = REG_AW'(idx);
        wd = DATA_W'(val);
        tick();
        we = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, out_valid, 1'b0);
        check({tag, "_busy"},  busy,      1'b0);
        check({tag, "_done"},  done,      1'b0);
        check({tag, "_ra"},    ra,        5'd0);
    endtask

    // mode 0: out_ready tied high; mode 1: out_ready pattern 1,0,0 by cycle.
    // restart_beat >= 0: hold start high while that beat is in flight.
    // abort_beat >= 0: assert reset while that beat is valid.
    task automatic run_dump(input string tag, input int mode, input int restart_beat,
                            input int abort_beat);
        int               cyc;
        int               beats;
        int               last_hs;
        int               first_valid;
        logic             prev_wait;
        logic [63:0]      prev_data;
        logic [4:0]       prev_idx;
        logic             finished;
        logic             aborted;
        beats = 0; last_hs = -1; first_valid = -1;
        prev_wait = 1'b0; prev_data = '0; prev_idx = '0;
        finished = 1'b0; aborted = 1'b0;
        out_ready = 1'b1;
        start = 1'b1;
        cyc = 0;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!finished && cyc < 400) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            start = (restart_beat >= 0) && (beats == restart_beat);
            if (abort_beat >= 0 && out_valid && out_idx == 5'(abort_beat)) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check({tag, "_rst_valid"}, out_valid, 1'b0);
                check({tag, "_rst_busy"},  busy,      1'b0);
                check({tag, "_rst_done"},  done,      1'b0);
                check({tag, "_rst_ra"},    ra,        5'd0);
                check({tag, "_rst_data"},  out_data,  64'd0);
                check({tag, "_rst_idx"},   out_idx,   5'd0);
                for (int k = 0; k < 4; k++) begin
                    tick();
                    check_idle({tag, "_after_rst"});
                end
                aborted  = 1'b1;
                finished = 1'b1;
            end else begin
                if (prev_wait) check({tag, "_valid_held"}, out_valid, 1'b1);
                if (out_valid) begin
                    if (first_valid < 0) begin
                        first_valid = cyc;
                        check({tag, "_first_latency"}, 64'(cyc), 64'd2);
                    end
                    check({tag, "_ra_eq_idx"}, ra, out_idx);
                    check({tag, "_busy_valid"}, busy, 1'b1);
                    if (prev_wait) begin
                        check({tag, "_hold_data"}, out_data, prev_data);
                        check({tag, "_hold_idx"},  out_idx,  prev_idx);
                    end
                    if (out_ready) begin
                        check({tag, "_beat_idx"},  out_idx,  64'(beats));
                        check({tag, "_beat_data"}, out_data, exp_data(beats));
                        if (mode == 0 && last_hs >= 0)
                            check({tag, "_beat_spacing"}, 64'(cyc - last_hs), 64'd2);
                        last_hs   = cyc;
                        beats++;
                        prev_wait = 1'b0;
                    end else begin
                        prev_wait = 1'b1;
                        prev_data = out_data;
                        prev_idx  = out_idx;
                    end
                end else begin
                    prev_wait = 1'b0;
                end
                if (done) begin
                    check({tag, "_done_latency"}, 64'(cyc - last_hs), 64'd2);
                    check({tag, "_beat_count"},   64'(beats), 64'(LAST + 1));
                    if (mode == 0)
                        check({tag, "_dump_cycles"}, 64'(cyc), 64'(2 * (LAST + 1) + 2));
                    finished = 1'b1;
                end
                tick();
                cyc++;
            end
        end
        start = 1'b0;
        check({tag, "_finished"}, finished, 1'b1);
        if (!aborted) begin
            // done must already be gone on the next cycle, and stay gone.
            for (int k = 0; k < 3; k++) check_idle({tag, "_post"});
            for (int k = 0; k < 3; k++) begin
                tick();
                check_idle({tag, "_post_idle"});
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; out_ready = 1'b1;
        we = 1'b0; wa = '0; wd = '0;
        tick();
        tick();
        // Reset has priority over a start arriving in the same cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        check_idle("reset");
        check("reset_data", out_data, 64'd0);
        check("reset_idx",  out_idx,  5'd0);

        for (int n = 0; n <= 30; n++) write_reg(n, n);
        tick();
        check_idle("preload");

        run_dump("full", 0, -1, -1);
        run_dump("backpr", 1, -1, -1);
        run_dump("restart", 0, 10, -1);
        run_dump("abort", 0, -1, 5);
        run_dump("fresh", 0, -1, -1);

        write_reg(5, 15);
        x5_val = 15;
        tick();
        run_dump("x5new", 0, -1, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_regfile_dump
